// File: rtl/sys_defs.sv
// Shared memory-interface types for the requester/responder pair.
// Tags are 1..NUM_MEM_TAGS; tag value 0 means "no tag".
package sys_defs;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  localparam int NUM_MEM_TAGS   = 15;
  localparam int MEM_CNT_W      = 5;
  localparam int BLOCK_OFFSET_W = 3;

  // Tag slot i (0-based, used for per-tag arrays) carries tag value i+1.
  function automatic MEM_TAG tag_of_slot(input int slot);
    return MEM_TAG'(slot + 1);
  endfunction

endpackage

// File: rtl/mem_tag_alloc.sv
// Lowest-free-tag picker: slot i of busy_i corresponds to tag i+1.
// Output is 0 when every tag is busy.
module mem_tag_alloc
  import sys_defs::*;
(
  input  logic [NUM_MEM_TAGS-1:0] busy_i,
  output MEM_TAG                  free_tag_o
);

  // Scan high to low so the last (lowest) free slot wins.
  always_comb begin
    free_tag_o = '0;
    for (int i = NUM_MEM_TAGS - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        free_tag_o = tag_of_slot(i);
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency tagged memory model: block-aligned backing store, up to
// NUM_MEM_TAGS loads in flight, one registered data return per cycle.
module mem_responder
  import sys_defs::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int MEM_DEPTH   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  MEM_COMMAND proc2mem_command,
  input  ADDR        proc2mem_addr,
  input  MEM_BLOCK   proc2mem_data,
  output MEM_TAG     mem2proc_transaction_tag,
  output MEM_BLOCK   mem2proc_data,
  output MEM_TAG     mem2proc_data_tag
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [MEM_CNT_W-1:0] LAT_CNT = MEM_CNT_W'(MEM_LATENCY);

  // Request handshake: a LOAD/STORE presented in a cycle is accepted in that
  // same cycle iff mem2proc_transaction_tag is nonzero; a zero tag means the
  // request left no trace and the requester must present it again.

  logic [IDX_W-1:0] idx;
  MEM_BLOCK         rd_data;
  MEM_TAG           alloc_tag;
  logic             req_valid;
  logic             load_acc;
  logic             store_acc;
  logic             unused_addr_bits;

  MEM_BLOCK mem_q [MEM_DEPTH];

  logic [NUM_MEM_TAGS-1:0] busy_q, busy_d;
  logic [MEM_CNT_W-1:0]    cnt_q  [NUM_MEM_TAGS];
  logic [MEM_CNT_W-1:0]    cnt_d  [NUM_MEM_TAGS];
  MEM_BLOCK                data_q [NUM_MEM_TAGS];
  MEM_BLOCK                data_d [NUM_MEM_TAGS];

  MEM_BLOCK ret_data_q, ret_data_d;
  MEM_TAG   ret_tag_q,  ret_tag_d;

  assign idx              = proc2mem_addr[BLOCK_OFFSET_W +: IDX_W];
  assign unused_addr_bits = ^{proc2mem_addr[BLOCK_OFFSET_W-1:0],
                              proc2mem_addr[31:BLOCK_OFFSET_W+IDX_W]};
  assign rd_data          = mem_q[idx];

  mem_tag_alloc u_tag_alloc (
    .busy_i     (busy_q),
    .free_tag_o (alloc_tag)
  );

  assign req_valid = reset && ((proc2mem_command == MEM_LOAD) ||
                               (proc2mem_command == MEM_STORE));
  assign load_acc  = req_valid && (proc2mem_command == MEM_LOAD)  && (alloc_tag != '0);
  assign store_acc = req_valid && (proc2mem_command == MEM_STORE) && (alloc_tag != '0);

  assign mem2proc_transaction_tag = req_valid ? alloc_tag : '0;
  assign mem2proc_data            = ret_data_q;
  assign mem2proc_data_tag        = ret_tag_q;

  // Backing store is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      mem_q[idx] <= proc2mem_data;
    end
  end

  // A tag at count 2 returns next cycle, so its data is staged into the
  // output register now; latency 1 stages straight from the store read.
  always_comb begin
    busy_d     = busy_q;
    ret_data_d = '0;
    ret_tag_d  = '0;
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      cnt_d[i]  = cnt_q[i];
      data_d[i] = data_q[i];
      if (busy_q[i]) begin
        if (cnt_q[i] == MEM_CNT_W'(1)) begin
          busy_d[i] = 1'b0;
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - MEM_CNT_W'(1);
        end
        if (cnt_q[i] == MEM_CNT_W'(2)) begin
          ret_data_d = data_q[i];
          ret_tag_d  = tag_of_slot(i);
        end
      end
      if (load_acc && (alloc_tag == tag_of_slot(i))) begin
        busy_d[i] = 1'b1;
        cnt_d[i]  = LAT_CNT;
        data_d[i] = rd_data;
      end
    end
    if (load_acc && (MEM_LATENCY == 1)) begin
      ret_data_d = rd_data;
      ret_tag_d  = alloc_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q     <= '0;
      ret_data_q <= '0;
      ret_tag_q  <= '0;
      for (int i = 0; i < NUM_MEM_TAGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      ret_data_q <= ret_data_d;
      ret_tag_q  <= ret_tag_d;
      for (int i = 0; i < NUM_MEM_TAGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Captured load data is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 4 and 20) checked every
// cycle against a due-cycle/free-from model, plus hand-computed scenarios.
module tb_mem_responder;
  import sys_defs::*;

  logic       clk;
  logic       reset;
  MEM_COMMAND cmd_a, cmd_b;
  ADDR        addr_a, addr_b;
  MEM_BLOCK   data_a, data_b;
  MEM_TAG     ttag_a, ttag_b, rtag_a, rtag_b;
  MEM_BLOCK   rdata_a, rdata_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic check_en = 1'b0;

  localparam int LAT_A = 4;
  localparam int LAT_B = 20;

  mem_responder #(.MEM_LATENCY(LAT_A), .MEM_DEPTH(256)) dut_a (
    .clk                      (clk),
    .reset                    (reset),
    .proc2mem_command         (cmd_a),
    .proc2mem_addr            (addr_a),
    .proc2mem_data            (data_a),
    .mem2proc_transaction_tag (ttag_a),
    .mem2proc_data            (rdata_a),
    .mem2proc_data_tag        (rtag_a)
  );

  mem_responder #(.MEM_LATENCY(LAT_B), .MEM_DEPTH(256)) dut_b (
    .clk                      (clk),
    .reset                    (reset),
    .proc2mem_command         (cmd_b),
    .proc2mem_addr            (addr_b),
    .proc2mem_data            (data_b),
    .mem2proc_transaction_tag (ttag_b),
    .mem2proc_data            (rdata_b),
    .mem2proc_data_tag        (rtag_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model / scoreboard ----------------
  typedef struct packed {
    int           inst;
    int           due;
    logic [3:0]   tag;
    logic [63:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem_m   [2][256];
  int          free_from [2][16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_inst(input int k, input logic [3:0] ttag, input logic [3:0] rtag,
                            input logic [63:0] rdata, input MEM_COMMAND c,
                            input logic [31:0] a, input logic [63:0] d);
    int          lat;
    logic [3:0]  exp_rt;
    logic [63:0] exp_rd;
    logic [3:0]  exp_tt;
    int          ix;
    lat    = (k == 0) ? LAT_A : LAT_B;
    exp_rt = '0;
    exp_rd = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i].inst == k && exp_q[i].due == cyc) begin
        exp_rt = exp_q[i].tag;
        exp_rd = exp_q[i].data;
      end
    end
    chk((k == 0) ? "ret_tag_a" : "ret_tag_b", {60'd0, rtag}, {60'd0, exp_rt});
    chk((k == 0) ? "ret_data_a" : "ret_data_b", rdata, exp_rd);
    exp_tt = '0;
    if (reset && (c == MEM_LOAD || c == MEM_STORE)) begin
      for (int t = 15; t >= 1; t--) begin
        if (free_from[k][t] <= cyc) exp_tt = 4'(t);
      end
    end
    chk((k == 0) ? "txn_tag_a" : "txn_tag_b", {60'd0, ttag}, {60'd0, exp_tt});
    ix = int'(a[10:3]);
    if (!reset) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].inst == k && exp_q[i].due > cyc) exp_q.delete(i);
      end
      for (int t = 0; t < 16; t++) free_from[k][t] = cyc + 1;
    end else if (exp_tt != '0) begin
      if (c == MEM_STORE) begin
        mem_m[k][ix] = d;
      end else begin
        exp_q.push_back('{inst: k, due: cyc + lat, tag: exp_tt, data: mem_m[k][ix]});
        free_from[k][exp_tt] = cyc + lat + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      model_inst(0, ttag_a, rtag_a, rdata_a, cmd_a, addr_a, data_a);
      model_inst(1, ttag_b, rtag_b, rdata_b, cmd_b, addr_b, data_b);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due <= cyc) exp_q.delete(i);
      end
      cyc++;
    end
  end

  // ---------------- drivers ----------------
  task automatic req_a(input MEM_COMMAND c, input logic [31:0] a, input logic [63:0] d,
                       output MEM_TAG tt, output MEM_TAG rt, output logic [63:0] rd);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    cmd_a  = c;    addr_a = a;    data_a = d;
    cmd_b  = MEM_NONE;
    #3;
    tt = ttag_a; rt = rtag_a; rd = rdata_a;
  endtask

  task automatic req_b(input MEM_COMMAND c, input logic [31:0] a,
                       output MEM_TAG tt, output MEM_TAG rt);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    cmd_b  = c;    addr_b = a;    data_b = '0;
    cmd_a  = MEM_NONE;
    #3;
    tt = ttag_b; rt = rtag_b;
  endtask

  task automatic idle(input int n);
    MEM_TAG tt, rt;
    logic [63:0] rd;
    for (int i = 0; i < n; i++) req_a(MEM_NONE, '0, '0, tt, rt, rd);
  endtask

  function automatic MEM_COMMAND pick_cmd();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return MEM_LOAD;
    if (r < 7) return MEM_STORE;
    return MEM_NONE;
  endfunction

  // ---------------- stimulus ----------------
  localparam logic [63:0] VAL_A = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] VAL_B = 64'h01234567_89ABCDEF;
  localparam logic [63:0] VAL_X = 64'h5555AAAA_12340000;

  initial begin
    MEM_TAG      tt, rt;
    logic [63:0] rd;
    int          first;
    MEM_TAG      got_rt;
    logic [63:0] got_rd;

    reset = 1'b0;
    cmd_a = MEM_NONE; addr_a = '0; data_a = '0;
    cmd_b = MEM_NONE; addr_b = '0; data_b = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_en = 1'b1;
    #3;
    chk("reset_txn_tag", {60'd0, ttag_a}, 64'd0);
    chk("reset_ret_tag", {60'd0, rtag_a}, 64'd0);
    chk("reset_ret_data", rdata_a, 64'd0);

    // Fill both stores so every later load has defined data.
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      cmd_a = MEM_STORE; addr_a = 32'(i * 8); data_a = {$urandom, $urandom};
      cmd_b = MEM_STORE; addr_b = 32'(i * 8); data_b = {$urandom, $urandom};
    end
    idle(25);

    // Store then load 0x40; return exactly 4 cycles after the load.
    req_a(MEM_STORE, 32'h40, VAL_A, tt, rt, rd);
    chk("lit_store_tag", {60'd0, tt}, 64'd1);
    req_a(MEM_LOAD, 32'h40, '0, tt, rt, rd);
    chk("lit_load_tag", {60'd0, tt}, 64'd1);
    first = 0; got_rt = '0; got_rd = '0;
    for (int k = 1; k <= 8; k++) begin
      req_a(MEM_NONE, '0, '0, tt, rt, rd);
      if (rt != '0 && first == 0) begin
        first = k; got_rt = rt; got_rd = rd;
      end
    end
    chk("lit_latency", 64'(first), 64'd4);
    chk("lit_ret_tag", {60'd0, got_rt}, 64'd1);
    chk("lit_ret_data", got_rd, VAL_A);

    // Back-to-back loads after storing 1,2,3.
    req_a(MEM_STORE, 32'h00, 64'd1, tt, rt, rd);
    req_a(MEM_STORE, 32'h08, 64'd2, tt, rt, rd);
    req_a(MEM_STORE, 32'h10, 64'd3, tt, rt, rd);
    for (int k = 0; k < 3; k++) begin
      req_a(MEM_LOAD, 32'(k * 8), '0, tt, rt, rd);
      chk("lit_b2b_tag", {60'd0, tt}, 64'(k + 1));
    end
    req_a(MEM_NONE, '0, '0, tt, rt, rd);
    chk("lit_b2b_gap", {60'd0, rt}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      req_a(MEM_NONE, '0, '0, tt, rt, rd);
      chk("lit_b2b_rtag", {60'd0, rt}, 64'(k + 1));
      chk("lit_b2b_data", rd, 64'(k + 1));
    end
    idle(6);

    // Load sees the value from its own request cycle, not a later store.
    req_a(MEM_LOAD, 32'h40, '0, tt, rt, rd);
    req_a(MEM_STORE, 32'h40, VAL_B, tt, rt, rd);
    chk("lit_raw_store_tag", {60'd0, tt}, 64'd2);
    for (int k = 0; k < 3; k++) req_a(MEM_NONE, '0, '0, tt, rt, rd);
    chk("lit_old_value", rd, VAL_A);
    idle(6);
    req_a(MEM_LOAD, 32'h40, '0, tt, rt, rd);
    for (int k = 0; k < 4; k++) req_a(MEM_NONE, '0, '0, tt, rt, rd);
    chk("lit_new_value", rd, VAL_B);
    idle(6);

    // 0x800 aliases index 0 with a 256-entry store.
    req_a(MEM_STORE, 32'h0, VAL_X, tt, rt, rd);
    req_a(MEM_LOAD, 32'h800, '0, tt, rt, rd);
    chk("lit_alias_tag", {60'd0, tt}, 64'd1);
    for (int k = 0; k < 4; k++) req_a(MEM_NONE, '0, '0, tt, rt, rd);
    chk("lit_alias_data", rd, VAL_X);
    idle(6);

    // Reset with two loads in flight: no returns, tag 1 reissued, data kept.
    req_a(MEM_LOAD, 32'h08, '0, tt, rt, rd);
    req_a(MEM_LOAD, 32'h10, '0, tt, rt, rd);
    @(posedge clk);
    #1;
    reset = 1'b0; cmd_a = MEM_NONE; cmd_b = MEM_NONE;
    for (int k = 0; k < 10; k++) begin
      req_a(MEM_NONE, '0, '0, tt, rt, rd);
      chk("lit_flushed", {60'd0, rt}, 64'd0);
    end
    req_a(MEM_LOAD, 32'h40, '0, tt, rt, rd);
    chk("lit_post_reset_tag", {60'd0, tt}, 64'd1);
    for (int k = 0; k < 4; k++) req_a(MEM_NONE, '0, '0, tt, rt, rd);
    chk("lit_post_reset_data", rd, VAL_B);
    idle(25);

    // Latency-20 instance: exhaust all 15 tags.
    for (int k = 0; k < 16; k++) begin
      req_b(MEM_LOAD, 32'(k * 8), tt, rt);
      chk("lit_exhaust_tag", {60'd0, tt}, (k < 15) ? 64'(k + 1) : 64'd0);
    end
    for (int k = 16; k < 20; k++) begin
      req_b(MEM_NONE, '0, tt, rt);
      chk("lit_l20_early", {60'd0, rt}, 64'd0);
    end
    req_b(MEM_NONE, '0, tt, rt);
    chk("lit_l20_first_ret", {60'd0, rt}, 64'd1);
    req_b(MEM_LOAD, 32'h18, tt, rt);
    chk("lit_l20_reuse", {60'd0, tt}, 64'd1);
    idle(25);

    // Random traffic on both instances, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset  = ($urandom_range(0, 199) != 0);
      cmd_a  = pick_cmd();
      addr_a = 32'($urandom_range(0, 4095));
      data_a = {$urandom, $urandom};
      cmd_b  = pick_cmd();
      addr_b = 32'($urandom_range(0, 4095));
      data_b = {$urandom, $urandom};
    end
    idle(25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
